// File: rtl/cnl_seq_pkg.sv
// Shared types for the CNN layer job sequencer: FSM states, error codes and
// the queued job descriptor.
package cnl_seq_pkg;

    localparam int CNL_PARAM_WIDTH = 128;
    localparam int CNL_CNT_WIDTH   = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_FETCH,
        ST_RUN,
        ST_CHECK,
        ST_ACK
    } seq_state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_COUNT    = 2'd1;
    localparam logic [1:0] ERR_PROTOCOL = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    // The payload widths track the default quad configuration.
    typedef struct packed {
        logic [CNL_PARAM_WIDTH-1:0] params;
        logic [CNL_CNT_WIDTH-1:0]   num_results;
    } cnl_desc_t;

endpackage

// File: rtl/cnl_seq_fifo.sv
// Synchronous descriptor FIFO with full/empty flags; the head entry is read
// straight from the storage flops so it is valid the cycle after a push.
module cnl_seq_fifo #(
    parameter int WIDTH = 152,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cnl_job_sequencer.sv
// Queue-driven job dispatcher for one cnn_layer_accel_quad. Optional watchdog
// is enabled by defining CNL_SEQ_TIMEOUT_EN.
module cnl_job_sequencer
    import cnl_seq_pkg::*;
#(
    parameter int C_PARAM_WIDTH = CNL_PARAM_WIDTH,
    parameter int C_JOB_DEPTH   = 8,
    parameter int C_CNT_WIDTH   = CNL_CNT_WIDTH,
    parameter int C_DONE_WIDTH  = 16,
    parameter int C_TIMEOUT_CYC = 65535
) (
    input  logic                     clk_if,
    input  logic                     rst,
    input  logic                     desc_valid,
    output logic                     desc_ready,
    input  logic [C_PARAM_WIDTH-1:0] desc_params,
    input  logic [C_CNT_WIDTH-1:0]   desc_num_results,
    output logic                     job_start,
    input  logic                     job_accept,
    output logic [C_PARAM_WIDTH-1:0] job_parameters,
    input  logic                     job_fetch_request,
    output logic                     job_fetch_ack,
    input  logic                     job_fetch_complete,
    input  logic                     job_complete,
    output logic                     job_complete_ack,
    input  logic                     result_valid,
    input  logic                     result_accept,
    output logic                     busy,
    output logic [C_DONE_WIDTH-1:0]  jobs_done,
    output logic                     seq_error,
    output logic [1:0]               err_code
);

    seq_state_t             state, state_next;
    cnl_desc_t              push_desc, head_desc;
    logic                   fifo_full, fifo_empty, fifo_pop;
    logic                   ready_en;
    logic                   proto_err, timeout_hit, job_taken, beat;
    logic [C_CNT_WIDTH-1:0] exp_cnt, res_cnt;

    assign push_desc.params      = desc_params;
    assign push_desc.num_results = desc_num_results;
    assign desc_ready = ready_en && !fifo_full;
    assign busy       = (state != ST_IDLE) || !fifo_empty;
    assign job_taken  = (state == ST_START) && job_accept && !timeout_hit;
    assign beat       = ((state == ST_FETCH) || (state == ST_RUN)) && result_valid && result_accept;

    cnl_seq_fifo #(
        .WIDTH ($bits(cnl_desc_t)),
        .DEPTH (C_JOB_DEPTH)
    ) u_fifo (
        .clk       (clk_if),
        .rst       (rst),
        .push      (desc_valid && desc_ready),
        .push_data (push_desc),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head_desc)
    );

`ifdef CNL_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(C_TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clk_if) begin
        if (rst || (state_next != state)) wd_cnt <= '0;
        else if (wd_cnt != '1)            wd_cnt <= wd_cnt + WD_W'(1);
    end

    assign timeout_hit = ((state == ST_START) || (state == ST_FETCH) || (state == ST_RUN))
                         && (wd_cnt >= WD_W'(C_TIMEOUT_CYC - 1));
`else
    logic timeout_unused;
    assign timeout_unused = (C_TIMEOUT_CYC != 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk_if) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // A timed-out job in START is dropped so the same descriptor is not re-offered forever.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        proto_err  = 1'b0;
        case (state)
            ST_IDLE:  if (!fifo_empty) state_next = ST_START;
            ST_START: begin
                if (timeout_hit || job_accept) fifo_pop = 1'b1;
                if (timeout_hit)     state_next = ST_IDLE;
                else if (job_accept) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (timeout_hit) state_next = ST_IDLE;
                else if (job_complete) begin
                    proto_err  = 1'b1;
                    state_next = ST_CHECK;
                end else if (job_fetch_complete) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (timeout_hit)       state_next = ST_IDLE;
                else if (job_complete) state_next = ST_CHECK;
            end
            ST_CHECK: state_next = ST_ACK;
            ST_ACK:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_if) begin
        if (rst) begin
            ready_en         <= 1'b0;
            job_start        <= 1'b0;
            job_parameters   <= '0;
            job_fetch_ack    <= 1'b0;
            job_complete_ack <= 1'b0;
            exp_cnt          <= '0;
            res_cnt          <= '0;
            jobs_done        <= '0;
            seq_error        <= 1'b0;
            err_code         <= ERR_NONE;
        end else begin
            ready_en         <= 1'b1;
            job_start        <= (state_next == ST_START);
            job_complete_ack <= (state_next == ST_ACK);
            job_fetch_ack    <= (state == ST_FETCH) && job_fetch_request && !job_fetch_ack;
            if (state_next == ST_START) job_parameters <= head_desc.params;

            if (job_taken) begin
                exp_cnt <= head_desc.num_results;
                res_cnt <= '0;
            end else if (beat && (res_cnt != '1)) begin
                res_cnt <= res_cnt + C_CNT_WIDTH'(1);
            end

            if (state == ST_ACK) jobs_done <= jobs_done + C_DONE_WIDTH'(1);

            // Only the first error is kept until reset.
            if (!seq_error) begin
                if (proto_err) begin
                    seq_error <= 1'b1;
                    err_code  <= ERR_PROTOCOL;
                end else if ((state == ST_CHECK) && (res_cnt != exp_cnt)) begin
                    seq_error <= 1'b1;
                    err_code  <= ERR_COUNT;
                end else if (timeout_hit) begin
                    seq_error <= 1'b1;
                    err_code  <= ERR_TIMEOUT;
                end
            end
        end
    end

endmodule

// File: tb/tb_cnl_job_sequencer.sv
// Directed self-checking bench for cnl_job_sequencer (default build, watchdog off).
module tb_cnl_job_sequencer;

    logic         clk_if = 1'b0;
    logic         rst;
    logic         desc_valid;
    logic         desc_ready;
    logic [127:0] desc_params;
    logic [23:0]  desc_num_results;
    logic         job_start;
    logic         job_accept;
    logic [127:0] job_parameters;
    logic         job_fetch_request;
    logic         job_fetch_ack;
    logic         job_fetch_complete;
    logic         job_complete;
    logic         job_complete_ack;
    logic         result_valid;
    logic         result_accept;
    logic         busy;
    logic [15:0]  jobs_done;
    logic         seq_error;
    logic [1:0]   err_code;

    int total = 0;
    int bad   = 0;

    always #5 clk_if = ~clk_if;

    cnl_job_sequencer dut (
        .clk_if             (clk_if),
        .rst                (rst),
        .desc_valid         (desc_valid),
        .desc_ready         (desc_ready),
        .desc_params        (desc_params),
        .desc_num_results   (desc_num_results),
        .job_start          (job_start),
        .job_accept         (job_accept),
        .job_parameters     (job_parameters),
        .job_fetch_request  (job_fetch_request),
        .job_fetch_ack      (job_fetch_ack),
        .job_fetch_complete (job_fetch_complete),
        .job_complete       (job_complete),
        .job_complete_ack   (job_complete_ack),
        .result_valid       (result_valid),
        .result_accept      (result_accept),
        .busy               (busy),
        .jobs_done          (jobs_done),
        .seq_error          (seq_error),
        .err_code           (err_code)
    );

    task automatic tick();
        @(posedge clk_if);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [127:0] paramsFor(input int i);
        return {96'hC0FFEE_0000_1234_5678, 32'(i)};
    endfunction

    // One push cycle; the descriptor is taken at the next clock edge if ready.
    task automatic applyStimulus(input logic [127:0] p, input logic [23:0] n);
        desc_valid       = 1'b1;
        desc_params      = p;
        desc_num_results = n;
        tick();
        desc_valid       = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_desc_ready"}, 128'(desc_ready), 128'(0));
        checkOutput({tag, "_job_start"}, 128'(job_start), 128'(0));
        checkOutput({tag, "_job_params"}, job_parameters, 128'(0));
        checkOutput({tag, "_fetch_ack"}, 128'(job_fetch_ack), 128'(0));
        checkOutput({tag, "_cmpl_ack"}, 128'(job_complete_ack), 128'(0));
        checkOutput({tag, "_busy"}, 128'(busy), 128'(0));
        checkOutput({tag, "_jobs_done"}, 128'(jobs_done), 128'(0));
        checkOutput({tag, "_seq_error"}, 128'(seq_error), 128'(0));
        checkOutput({tag, "_err_code"}, 128'(err_code), 128'(0));
    endtask

    task automatic waitJobStart(input string tag);
        for (int n = 0; n < 20 && job_start !== 1'b1; n++) tick();
        checkOutput({tag, "_start_seen"}, 128'(job_start), 128'(1));
    endtask

    // Drives one job from accept to ack; the last beat shares its cycle with job_complete.
    task automatic runJob(input string tag, input logic [127:0] exp_params, input int beats);
        waitJobStart(tag);
        checkOutput({tag, "_params"}, job_parameters, exp_params);
        job_accept = 1'b1;
        tick();
        job_accept = 1'b0;
        checkOutput({tag, "_start_drop"}, 128'(job_start), 128'(0));
        job_fetch_request = 1'b1;
        tick();
        job_fetch_request = 1'b0;
        checkOutput({tag, "_fetch_ack"}, 128'(job_fetch_ack), 128'(1));
        tick();
        checkOutput({tag, "_fetch_ack_end"}, 128'(job_fetch_ack), 128'(0));
        job_fetch_complete = 1'b1;
        tick();
        job_fetch_complete = 1'b0;
        result_valid  = 1'b1;
        result_accept = 1'b1;
        for (int b = 1; b < beats; b++) tick();
        job_complete = 1'b1;
        tick();
        job_complete  = 1'b0;
        result_valid  = 1'b0;
        result_accept = 1'b0;
        checkOutput({tag, "_ack_early"}, 128'(job_complete_ack), 128'(0));
        tick();
        checkOutput({tag, "_ack"}, 128'(job_complete_ack), 128'(1));
        tick();
        checkOutput({tag, "_ack_end"}, 128'(job_complete_ack), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        rst                = 1'b1;
        desc_valid         = 1'b0;
        desc_params        = '0;
        desc_num_results   = '0;
        job_accept         = 1'b0;
        job_fetch_request  = 1'b0;
        job_fetch_complete = 1'b0;
        job_complete       = 1'b0;
        result_valid       = 1'b0;
        result_accept      = 1'b0;

        repeat (3) tick();
        checkResetOutputs("reset");
        rst = 1'b0;
        checkOutput("ready_during_release", 128'(desc_ready), 128'(0));
        tick();
        checkOutput("ready_after_release", 128'(desc_ready), 128'(1));

        // Single 20x20 / 3x3 job: 324 beats, exact latency of job_start.
        applyStimulus(paramsFor(100), 24'd324);
        checkOutput("t1_start_lat1", 128'(job_start), 128'(0));
        checkOutput("t1_busy_queued", 128'(busy), 128'(1));
        tick();
        checkOutput("t1_start_lat2", 128'(job_start), 128'(1));
        runJob("t1", paramsFor(100), 324);
        checkOutput("t1_jobs_done", 128'(jobs_done), 128'(1));
        checkOutput("t1_seq_error", 128'(seq_error), 128'(0));
        checkOutput("t1_busy_idle", 128'(busy), 128'(0));

        // Fill the queue with the quad refusing jobs, then drain in order.
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("t2_ready_%0d", i), 128'(desc_ready), 128'(1));
            applyStimulus(paramsFor(i), 24'(i + 1));
        end
        checkOutput("t2_ready_full", 128'(desc_ready), 128'(0));
        applyStimulus(paramsFor(999), 24'd1);
        checkOutput("t2_still_full", 128'(desc_ready), 128'(0));
        for (int i = 0; i < 8; i++) runJob($sformatf("t2_job%0d", i), paramsFor(i), i + 1);
        checkOutput("t2_jobs_done", 128'(jobs_done), 128'(9));
        checkOutput("t2_busy_drained", 128'(busy), 128'(0));
        checkOutput("t2_ready_again", 128'(desc_ready), 128'(1));
        tick();
        checkOutput("t2_no_ninth", 128'(job_start), 128'(0));
        checkOutput("t2_seq_error", 128'(seq_error), 128'(0));

        // 25x25 job one beat short, followed by a clean job.
        applyStimulus(paramsFor(200), 24'd529);
        applyStimulus(paramsFor(201), 24'd5);
        runJob("t3_short", paramsFor(200), 528);
        checkOutput("t3_err_code", 128'(err_code), 128'(1));
        checkOutput("t3_seq_error", 128'(seq_error), 128'(1));
        runJob("t3_next", paramsFor(201), 5);
        checkOutput("t3_jobs_done", 128'(jobs_done), 128'(11));
        checkOutput("t3_err_hold", 128'(err_code), 128'(1));

        // Reset while a job is in RUN with another one queued.
        applyStimulus(paramsFor(300), 24'd50);
        applyStimulus(paramsFor(301), 24'd50);
        waitJobStart("t5");
        job_accept = 1'b1;
        tick();
        job_accept = 1'b0;
        job_fetch_complete = 1'b1;
        tick();
        job_fetch_complete = 1'b0;
        result_valid  = 1'b1;
        result_accept = 1'b1;
        repeat (4) tick();
        result_valid  = 1'b0;
        result_accept = 1'b0;
        rst = 1'b1;
        tick();
        checkResetOutputs("t5_rst");
        rst = 1'b0;
        repeat (3) begin
            tick();
            checkOutput("t5_no_ack", 128'(job_complete_ack), 128'(0));
            checkOutput("t5_no_start", 128'(job_start), 128'(0));
        end
        applyStimulus(paramsFor(302), 24'd7);
        runJob("t5_after", paramsFor(302), 7);
        checkOutput("t5_jobs_done", 128'(jobs_done), 128'(1));
        checkOutput("t5_seq_error", 128'(seq_error), 128'(0));

        // job_complete while still fetching.
        applyStimulus(paramsFor(400), 24'd10);
        waitJobStart("t4");
        job_accept = 1'b1;
        tick();
        job_accept = 1'b0;
        job_fetch_request = 1'b1;
        tick();
        job_fetch_request = 1'b0;
        job_complete = 1'b1;
        tick();
        job_complete = 1'b0;
        checkOutput("t4_err_code", 128'(err_code), 128'(2));
        checkOutput("t4_seq_error", 128'(seq_error), 128'(1));
        tick();
        checkOutput("t4_ack", 128'(job_complete_ack), 128'(1));
        tick();
        checkOutput("t4_ack_end", 128'(job_complete_ack), 128'(0));
        checkOutput("t4_jobs_done", 128'(jobs_done), 128'(2));
        checkOutput("t4_idle", 128'(busy), 128'(0));
        checkOutput("t4_err_hold", 128'(err_code), 128'(2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
